uart_fifo_sync_param: RTL and testbench

Parametrised single-clock synchronous FIFO, the next-generation TX/RX buffer for the UART core. It generalises the fixed 256x8 FIFO in width and depth, uses the full depth, and adds a selectable first-word-fall-through (FWFT) mode, an occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. It sits between the APB register interface and the UART TX/RX shift logic. It runs entirely on the system clock.

---
 rtl/uart_fifo_sync_param.sv | 117 +++++++++++
 tb/tb_uart_fifo_sync_param.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_sync_param.sv
// rtl/uart_fifo_sync_param.sv - parametrised single-clock FIFO with FWFT option, thresholds and sticky errors
module uart_fifo_sync_param #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 8,
  parameter int FWFT       = 0,
  parameter int AFULL_TH   = (1 << DEPTH_LOG2) - 4,
  parameter int AEMPTY_TH  = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic                  write_n,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  read_n,
  input  logic [DEPTH_LOG2:0]   level,
  output logic [WIDTH-1:0]      data_out,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  half,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [CW-1:0]         CNT_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]         AFULL_C   = CW'(AFULL_TH);
  localparam logic [CW-1:0]         AEMPTY_C  = CW'(AEMPTY_TH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [WIDTH-1:0]      dout_q, dout_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic rd_ok, wr_ok, wr_rej, rd_rej;

  assign count        = count_q;
  assign full         = (count_q == CNT_DEPTH);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign half         = (count_q >= level);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // In FWFT mode the head word is shown live; dout_q keeps the last popped word for when the FIFO runs dry.
  assign data_out = ((FWFT != 0) && !empty) ? mem_q[rd_ptr_q] : dout_q;

  // A read frees a slot in the same cycle, so a write at full is accepted alongside it.
  assign rd_ok  = !read_n && !empty;
  assign wr_ok  = !write_n && (!full || rd_ok);
  assign wr_rej = !write_n && !wr_ok;
  assign rd_rej = !read_n && empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      dout_d   = '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        dout_d   = mem_q[rd_ptr_q];
      end
      if (wr_ok && !rd_ok) begin
        count_d = count_q + CNT_ONE;
      end else if (rd_ok && !wr_ok) begin
        count_d = count_q - CNT_ONE;
      end
    end
    ovf_d = wr_rej ? 1'b1 : (clr_err ? 1'b0 : ovf_q);
    unf_d = rd_rej ? 1'b1 : (clr_err ? 1'b0 : unf_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_ok && !flush) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

endmodule

// File: tb/tb_uart_fifo_sync_param.sv
// tb/tb_uart_fifo_sync_param.sv - directed bench for uart_fifo_sync_param, standard and FWFT instances
module tb_uart_fifo_sync_param;

  logic       clock;
  logic       reset_n;
  logic       flush;
  logic       clr_err;
  logic       write_n;
  logic [7:0] data_in;
  logic       read_n;
  logic [4:0] level;

  logic [7:0] s_dout, f_dout;
  logic [4:0] s_count, f_count;
  logic s_full, s_empty, s_af, s_ae, s_half, s_ovf, s_unf;
  logic f_full, f_empty, f_af, f_ae, f_half, f_ovf, f_unf;

  int checks = 0;
  int errors = 0;
  int nw = 0;
  int nr = 0;

  uart_fifo_sync_param #(.WIDTH(8), .DEPTH_LOG2(4), .FWFT(0)) u_std (
    .clock(clock), .reset_n(reset_n), .flush(flush), .clr_err(clr_err),
    .write_n(write_n), .data_in(data_in), .read_n(read_n), .level(level),
    .data_out(s_dout), .count(s_count), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .half(s_half),
    .overflow(s_ovf), .underflow(s_unf)
  );

  uart_fifo_sync_param #(.WIDTH(8), .DEPTH_LOG2(4), .FWFT(1)) u_fw (
    .clock(clock), .reset_n(reset_n), .flush(flush), .clr_err(clr_err),
    .write_n(write_n), .data_in(data_in), .read_n(read_n), .level(level),
    .data_out(f_dout), .count(f_count), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .half(f_half),
    .overflow(f_ovf), .underflow(f_unf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] val(input int n);
    return 8'(8'h80 + n);
  endfunction

  initial begin
    reset_n = 1'b0;
    flush   = 1'b0;
    clr_err = 1'b0;
    write_n = 1'b1;
    read_n  = 1'b1;
    data_in = 8'h00;
    level   = 5'd8;
    #2;
    chk("rst_count", 32'(s_count), 0);
    chk("rst_empty", 32'(s_empty), 1);
    chk("rst_full", 32'(s_full), 0);
    chk("rst_afull", 32'(s_af), 0);
    chk("rst_aempty", 32'(s_ae), 1);
    chk("rst_half", 32'(s_half), 0);
    chk("rst_ovf", 32'(s_ovf), 0);
    chk("rst_unf", 32'(s_unf), 0);
    chk("rst_dout", 32'(s_dout), 0);
    chk("rst_fw_dout", 32'(f_dout), 0);
    level = 5'd0;
    #1;
    chk("rst_half_lvl0", 32'(s_half), 1);
    level = 5'd8;
    tick();
    reset_n = 1'b1;

    // fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      write_n = 1'b0;
      data_in = 8'(i);
      tick();
      chk("fill_count", 32'(s_count), 32'(i + 1));
      chk("fill_afull", 32'(s_af), 32'((i + 1) >= 12));
      chk("fill_aempty", 32'(s_ae), 32'((i + 1) <= 4));
      chk("fill_half", 32'(s_half), 32'((i + 1) >= 8));
      chk("fill_full", 32'(s_full), 32'((i + 1) == 16));
    end
    data_in = 8'h55;
    tick();
    chk("ovf_count", 32'(s_count), 16);
    chk("ovf_flag", 32'(s_ovf), 1);
    chk("ovf_full", 32'(s_full), 1);
    write_n = 1'b1;

    // drain
    for (int i = 0; i < 16; i++) begin
      read_n = 1'b0;
      tick();
      chk("drain_dout", 32'(s_dout), 32'(i));
      chk("drain_count", 32'(s_count), 32'(15 - i));
    end
    chk("drain_empty", 32'(s_empty), 1);
    tick();
    chk("unf_flag", 32'(s_unf), 1);
    chk("unf_dout", 32'(s_dout), 32'h0F);
    chk("unf_ovf_sticky", 32'(s_ovf), 1);

    // clr_err together with a rejected read: rejection wins
    clr_err = 1'b1;
    tick();
    chk("clr_rej_unf", 32'(s_unf), 1);
    chk("clr_rej_ovf", 32'(s_ovf), 0);
    read_n = 1'b1;
    tick();
    chk("clr_unf", 32'(s_unf), 0);
    clr_err = 1'b0;

    // stream from count 5 across several wraps
    for (int i = 0; i < 5; i++) begin
      write_n = 1'b0;
      data_in = val(nw);
      nw++;
      tick();
    end
    chk("stream_pre_count", 32'(s_count), 5);
    for (int i = 0; i < 40; i++) begin
      write_n = 1'b0;
      read_n  = 1'b0;
      data_in = val(nw);
      nw++;
      tick();
      chk("stream_dout", 32'(s_dout), 32'(val(nr)));
      chk("stream_count", 32'(s_count), 5);
      nr++;
    end
    chk("stream_ovf", 32'(s_ovf), 0);
    chk("stream_unf", 32'(s_unf), 0);

    // fill to full, then simultaneous read and write
    read_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      data_in = val(nw);
      nw++;
      tick();
    end
    chk("full_count", 32'(s_count), 16);
    read_n  = 1'b0;
    data_in = val(nw);
    nw++;
    tick();
    chk("full_rw_count", 32'(s_count), 16);
    chk("full_rw_dout", 32'(s_dout), 32'(val(nr)));
    chk("full_rw_ovf", 32'(s_ovf), 0);
    nr++;
    read_n  = 1'b1;
    data_in = 8'hEE;
    tick();
    chk("full_wonly_ovf", 32'(s_ovf), 1);
    write_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      read_n = 1'b0;
      tick();
      chk("pre_flush_dout", 32'(s_dout), 32'(val(nr)));
      nr++;
    end
    chk("pre_flush_count", 32'(s_count), 7);

    // flush beats read and write; flags untouched
    flush   = 1'b1;
    write_n = 1'b0;
    read_n  = 1'b0;
    data_in = 8'h77;
    tick();
    chk("flush_count", 32'(s_count), 0);
    chk("flush_dout", 32'(s_dout), 0);
    chk("flush_empty", 32'(s_empty), 1);
    chk("flush_ovf", 32'(s_ovf), 1);
    chk("flush_unf", 32'(s_unf), 0);
    chk("flush_fw_count", 32'(f_count), 0);
    chk("flush_fw_dout", 32'(f_dout), 0);
    flush   = 1'b0;
    read_n  = 1'b1;

    // FWFT behaviour
    data_in = 8'hA5;
    tick();
    chk("fw_a5_dout", 32'(f_dout), 32'hA5);
    chk("fw_a5_empty", 32'(f_empty), 0);
    chk("std_a5_dout", 32'(s_dout), 0);
    data_in = 8'h3C;
    tick();
    chk("fw_head_hold", 32'(f_dout), 32'hA5);
    chk("fw_count2", 32'(f_count), 2);
    write_n = 1'b1;
    read_n  = 1'b0;
    tick();
    chk("fw_pop_dout", 32'(f_dout), 32'h3C);
    chk("fw_pop_count", 32'(f_count), 1);
    chk("std_pop_dout", 32'(s_dout), 32'hA5);
    tick();
    chk("fw_empty", 32'(f_empty), 1);
    chk("fw_empty_hold", 32'(f_dout), 32'h3C);
    chk("std_pop2_dout", 32'(s_dout), 32'h3C);
    read_n = 1'b1;

    // async reset mid-burst
    write_n = 1'b0;
    data_in = 8'h11;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_count", 32'(s_count), 0);
    chk("arst_empty", 32'(s_empty), 1);
    chk("arst_aempty", 32'(s_ae), 1);
    chk("arst_full", 32'(s_full), 0);
    chk("arst_half", 32'(s_half), 0);
    chk("arst_ovf", 32'(s_ovf), 0);
    chk("arst_dout", 32'(s_dout), 0);
    chk("arst_fw_dout", 32'(f_dout), 0);
    chk("arst_fw_empty", 32'(f_empty), 1);
    write_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
